// File: rtl/uart_avalon_slave.sv
// uart_avalon_slave: Avalon-MM polled UART register slave with 8N1 TX/RX engines.
module uart_avalon_slave #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_address,
  input  logic        i_read,
  output logic [31:0] o_readdata,
  input  logic        i_write,
  input  logic [31:0] i_writedata,
  output logic        o_waitrequest,
  input  logic        i_rxd,
  output logic        o_txd
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {TIDLE, TSTART, TDATA, TSTOP} tstate_t;
  typedef enum logic [1:0] {RIDLE, RSTART, RDATA, RSTOP} rstate_t;
  tstate_t tstate_q, tstate_d;
  rstate_t rstate_q, rstate_d;
  logic [CW-1:0] tcnt_q, tcnt_d, rcnt_q, rcnt_d;
  logic [2:0] tbit_q, tbit_d, rbit_q, rbit_d;
  logic [7:0] tsh_q, tsh_d, rsh_q, rsh_d, rxdata_q, rxdata_d;
  logic ack_q, ack_d, rrdy_q, rrdy_d, roe_q, roe_d, fe_q, fe_d;
  logic s1_q, s2_q, prev_q;
  logic rd, wr, rd0, wr4, wr8, trdy, rx_done;
  logic unused_wdata;
  assign unused_wdata = ^i_writedata[31:8];
  assign ack_d = (i_read | i_write) & ~ack_q;
  assign o_waitrequest = ~ack_q;
  assign rd = ack_q & i_read;
  assign wr = ack_q & i_write & ~i_read;
  assign rd0 = rd & (i_address == 5'd0);
  assign trdy = tstate_q == TIDLE;
  assign wr4 = wr & (i_address == 5'd4) & trdy;
  assign wr8 = wr & (i_address == 5'd8);
  assign o_readdata = !rd ? 32'd0 :
                      i_address == 5'd0 ? {24'd0, rxdata_q} :
                      i_address == 5'd8 ? {24'd0, rrdy_q, trdy, 2'b0, roe_q, fe_q, 2'b0} : 32'd0;
  assign o_txd = tstate_q == TSTART ? 1'b0 : tstate_q == TDATA ? tsh_q[tbit_q] : 1'b1;
  always_comb begin
    tstate_d = tstate_q;
    tcnt_d = tcnt_q + 1'b1;
    tbit_d = tbit_q;
    tsh_d = tsh_q;
    case (tstate_q)
      TIDLE: begin
        tcnt_d = '0;
        tbit_d = '0;
        if (wr4) begin
          tsh_d = i_writedata[7:0];
          tstate_d = TSTART;
        end
      end
      TSTART: if (tcnt_q == LAST) begin
        tcnt_d = '0;
        tstate_d = TDATA;
      end
      TDATA: if (tcnt_q == LAST) begin
        tcnt_d = '0;
        tbit_d = tbit_q + 3'd1;
        if (tbit_q == 3'd7) tstate_d = TSTOP;
      end
      TSTOP: if (tcnt_q == LAST) begin
        tcnt_d = '0;
        tstate_d = TIDLE;
      end
    endcase
  end
  // RSTART sample decides glitch vs. real start; stop sample delivers the byte
  always_comb begin
    rstate_d = rstate_q;
    rcnt_d = rcnt_q + 1'b1;
    rbit_d = rbit_q;
    rsh_d = rsh_q;
    rx_done = 1'b0;
    case (rstate_q)
      RIDLE: begin
        rcnt_d = '0;
        rbit_d = '0;
        if (prev_q & ~s2_q) rstate_d = RSTART;
      end
      RSTART: if (rcnt_q == HALF) begin
        rcnt_d = '0;
        rstate_d = s2_q ? RIDLE : RDATA;
      end
      RDATA: if (rcnt_q == LAST) begin
        rcnt_d = '0;
        rsh_d = {s2_q, rsh_q[7:1]};
        rbit_d = rbit_q + 3'd1;
        if (rbit_q == 3'd7) rstate_d = RSTOP;
      end
      RSTOP: if (rcnt_q == LAST) begin
        rcnt_d = '0;
        rx_done = 1'b1;
        rstate_d = RIDLE;
      end
    endcase
  end
  // a byte landing on the same cycle as its consuming read counts as read-then-refill
  always_comb begin
    rrdy_d = rx_done | (rrdy_q & ~rd0);
    roe_d = (rx_done & rrdy_q & ~rd0) | (roe_q & ~wr8);
    fe_d = (rx_done & ~s2_q) | (fe_q & ~wr8);
    rxdata_d = rx_done ? rsh_q : rxdata_q;
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ack_q <= 1'b0;
      tstate_q <= TIDLE;
      tcnt_q <= '0;
      tbit_q <= '0;
      tsh_q <= '0;
      rstate_q <= RIDLE;
      rcnt_q <= '0;
      rbit_q <= '0;
      rsh_q <= '0;
      rxdata_q <= '0;
      rrdy_q <= 1'b0;
      roe_q <= 1'b0;
      fe_q <= 1'b0;
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      ack_q <= ack_d;
      tstate_q <= tstate_d;
      tcnt_q <= tcnt_d;
      tbit_q <= tbit_d;
      tsh_q <= tsh_d;
      rstate_q <= rstate_d;
      rcnt_q <= rcnt_d;
      rbit_q <= rbit_d;
      rsh_q <= rsh_d;
      rxdata_q <= rxdata_d;
      rrdy_q <= rrdy_d;
      roe_q <= roe_d;
      fe_q <= fe_d;
      s1_q <= i_rxd;
      s2_q <= s1_q;
      prev_q <= s2_q;
    end
  end
endmodule

// File: tb/tb_uart_avalon_slave.sv
// tb_uart_avalon_slave: directed register-map vectors plus serial TX/RX sequences at 8 clocks per bit.
module tb_uart_avalon_slave;
  logic i_clk, i_rst, i_read, i_write, o_waitrequest, i_rxd, o_txd;
  logic [4:0] i_address;
  logic [31:0] i_writedata, o_readdata;
  int tests = 0, fails = 0, cyc = 0, t0 = 0;
  typedef struct {
    logic rd;
    logic wr;
    logic [4:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[10];
  uart_avalon_slave #(.CLKS_PER_BIT(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_address(i_address), .i_read(i_read),
    .o_readdata(o_readdata), .i_write(i_write), .i_writedata(i_writedata),
    .o_waitrequest(o_waitrequest), .i_rxd(i_rxd), .o_txd(o_txd)
  );
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic bus(input logic rd, input logic wr, input logic [4:0] a, input logic [31:0] wd,
                     output logic [31:0] rdata, output int waits);
    i_read = rd;
    i_write = wr;
    i_address = a;
    i_writedata = wd;
    waits = 0;
    @(negedge i_clk);
    while (o_waitrequest && waits < 20) begin
      waits++;
      @(negedge i_clk);
    end
    rdata = o_readdata;
    @(posedge i_clk);
    #1;
    i_read = 1'b0;
    i_write = 1'b0;
  endtask
  task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp, input string n);
    logic [31:0] d;
    int w;
    bus(1'b1, 1'b0, a, 32'd0, d, w);
    check(n, d, exp);
    check({n, "_lat"}, w, 1);
  endtask
  task automatic wr_chk(input logic [4:0] a, input logic [31:0] wd, input string n);
    logic [31:0] d;
    int w;
    bus(1'b0, 1'b1, a, wd, d, w);
    check({n, "_lat"}, w, 1);
  endtask
  task automatic go(input int k);
    while (cyc < t0 + k - 1) @(negedge i_clk);
    @(posedge i_clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] d, input logic sb);
    logic [9:0] f;
    f = {sb, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      i_rxd = f[i];
      repeat (8) @(posedge i_clk);
      #1;
    end
    i_rxd = 1'b1;
  endtask
  initial begin
    logic [9:0] fr;
    logic s [80];
    logic [31:0] d;
    int w;
    vt[0] = '{1'b1, 1'b0, 5'd8,  32'd0,        32'h40};
    vt[1] = '{1'b1, 1'b0, 5'd4,  32'd0,        32'h0};
    vt[2] = '{1'b1, 1'b0, 5'd0,  32'd0,        32'h0};
    vt[3] = '{1'b1, 1'b0, 5'd12, 32'd0,        32'h0};
    vt[4] = '{1'b1, 1'b0, 5'd31, 32'd0,        32'h0};
    vt[5] = '{1'b0, 1'b1, 5'd8,  32'hFFFFFFFF, 32'h0};
    vt[6] = '{1'b0, 1'b1, 5'd12, 32'h5A,       32'h0};
    vt[7] = '{1'b1, 1'b1, 5'd4,  32'h77,       32'h0};
    vt[8] = '{1'b1, 1'b0, 5'd8,  32'd0,        32'h40};
    vt[9] = '{1'b1, 1'b0, 5'd2,  32'd0,        32'h0};
    i_rst = 1'b1; i_read = 1'b0; i_write = 1'b0; i_address = '0; i_writedata = '0; i_rxd = 1'b1;
    #2 i_rst = 1'b0;
    #15;
    check("rst_txd", o_txd, 1);
    check("rst_wait", o_waitrequest, 1);
    check("rst_rdata", o_readdata, 0);
    @(negedge i_clk) i_rst = 1'b1;
    @(posedge i_clk); #1;
    for (int i = 0; i < 10; i++) begin
      bus(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, d, w);
      if (vt[i].rd) check($sformatf("vec%0d_data", i), d, vt[i].exp);
      check($sformatf("vec%0d_lat", i), w, 1);
    end
    // reset in the middle of a TX data bit
    wr_chk(5'd4, 32'h00, "rtx_wr");
    t0 = cyc;
    go(20);
    @(negedge i_clk);
    check("rtx_mid_txd", o_txd, 0);
    i_rst = 1'b0;
    #1;
    check("rtx_rst_txd", o_txd, 1);
    check("rtx_rst_wait", o_waitrequest, 1);
    check("rtx_rst_rdata", o_readdata, 0);
    @(negedge i_clk) i_rst = 1'b1;
    @(posedge i_clk); #1;
    rd_chk(5'd8, 32'h40, "rtx_status");
    // TX frame 0xA5 recorded cycle by cycle
    wr_chk(5'd4, 32'hA5, "txa5_wr");
    for (int i = 0; i < 80; i++) begin
      @(negedge i_clk);
      s[i] = o_txd;
    end
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      check($sformatf("txa5_b%0d_first", k), s[8*k], fr[k]);
      check($sformatf("txa5_b%0d_last", k), s[8*k+7], fr[k]);
    end
    @(posedge i_clk); #1;
    rd_chk(5'd8, 32'h40, "txa5_done");
    // TX while busy: second write must be dropped
    wr_chk(5'd4, 32'h11, "busy_wr1");
    t0 = cyc;
    fr = {1'b1, 8'h11, 1'b0};
    for (int k = 0; k < 10; k++) begin
      if (k == 1) begin go(5); wr_chk(5'd4, 32'h22, "busy_wr2"); end
      if (k == 5) begin go(40); rd_chk(5'd8, 32'h00, "busy_status"); end
      go(8*k + 4);
      @(negedge i_clk);
      check($sformatf("busy_b%0d", k), o_txd, fr[k]);
    end
    go(78);
    rd_chk(5'd8, 32'h00, "busy_cyc79");
    rd_chk(5'd8, 32'h40, "busy_cyc81");
    // RX single byte
    send_byte(8'h3C, 1'b1);
    rd_chk(5'd8, 32'hC0, "rx_status");
    rd_chk(5'd0, 32'h3C, "rx_data");
    rd_chk(5'd8, 32'h40, "rx_cleared");
    // overrun plus framing error
    send_byte(8'h01, 1'b1);
    repeat (3) @(posedge i_clk); #1;
    send_byte(8'h02, 1'b0);
    repeat (3) @(posedge i_clk); #1;
    rd_chk(5'd8, 32'hCC, "ovr_status");
    rd_chk(5'd0, 32'h02, "ovr_data");
    wr_chk(5'd8, 32'h0, "ovr_clr");
    rd_chk(5'd8, 32'h40, "ovr_after");
    // short low glitch
    i_rxd = 1'b0;
    repeat (2) @(posedge i_clk); #1;
    i_rxd = 1'b1;
    repeat (30) @(posedge i_clk); #1;
    rd_chk(5'd8, 32'h40, "glitch_status");
    // read of RX data completing on the stop-sample cycle
    send_byte(8'h33, 1'b1);
    repeat (3) @(posedge i_clk); #1;
    t0 = cyc;
    fork
      send_byte(8'h55, 1'b1);
      begin
        go(77);
        rd_chk(5'd0, 32'h33, "col_old");
      end
    join
    rd_chk(5'd8, 32'hC0, "col_status");
    rd_chk(5'd0, 32'h55, "col_new");
    rd_chk(5'd8, 32'h40, "col_final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
